// File: rtl/matrix_store_pkg.sv
// Shared types, constants and helpers for the matrix storage bank.
// Matrices are at most 5x5 with 4-bit elements, flattened row-major into
// 100 bits: element (i,j) lives at bits [(i*5+j)*4 +: 4].
package matrix_pkg;

  localparam int MAT_DIM_MAX = 5;
  localparam int ELEM_W      = 4;
  localparam int MAT_BITS    = MAT_DIM_MAX * MAT_DIM_MAX * ELEM_W;

  // Parser error_type codes; only ERR_NONE allows a capture.
  localparam logic [2:0] ERR_NONE = 3'b000;
  localparam logic [2:0] ERR_DIM  = 3'b001;
  localparam logic [2:0] ERR_VAL  = 3'b011;

  typedef logic [MAT_BITS-1:0] mat_t;
  typedef logic [3:0]          dim_t;
  typedef logic [2:0]          idx_t;
  typedef logic [2:0]          age_t;

  // Bit offset of element (i,j) inside a flattened matrix.
  function automatic int elem_off(input int i, input int j);
    return (i * MAT_DIM_MAX + j) * ELEM_W;
  endfunction

  // A dimension is usable when it lies in 1..MAT_DIM_MAX.
  function automatic logic dim_ok(input dim_t d);
    return (d >= 4'd1) && (d <= 4'(MAT_DIM_MAX));
  endfunction

  // Keep only the elements inside the m x n window; everything else reads 0
  // so stale upstream contents never leak into storage.
  function automatic mat_t mask_data(input mat_t d, input dim_t m, input dim_t n);
    mat_t r;
    r = '0;
    for (int i = 0; i < MAT_DIM_MAX; i++) begin
      for (int j = 0; j < MAT_DIM_MAX; j++) begin
        if ((4'(i) < m) && (4'(j) < n)) begin
          r[elem_off(i, j) +: ELEM_W] = d[elem_off(i, j) +: ELEM_W];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/matrix_store_if.sv
// Bus between the matrix-input parser / consumers (master) and the storage
// bank (slave).
//
// Handshake semantics: in_done is a one-cycle strobe with no back-pressure;
// a capture is acknowledged by a one-cycle wr_ack on the following cycle,
// with wr_idx/wr_replaced meaningful only while wr_ack is high. rd_en is
// sampled at each rising edge; exactly one cycle later rd_valid pulses for
// one cycle and rd_err/rd_m/rd_n/rd_data describe that read. The read
// outputs hold their last values while rd_valid is low. There is no ready
// signal: the bank accepts every strobe in the cycle it is presented.
interface matrix_store_if;
  import matrix_pkg::*;

  logic       in_done;
  logic [2:0] in_err;
  dim_t       in_m;
  dim_t       in_n;
  mat_t       in_data;
  logic       clr;
  logic       rd_en;
  idx_t       rd_idx;

  logic       rd_valid;
  logic       rd_err;
  dim_t       rd_m;
  dim_t       rd_n;
  mat_t       rd_data;
  logic       wr_ack;
  idx_t       wr_idx;
  logic       wr_replaced;
  logic [3:0] used_cnt;

  modport master (
    output in_done, in_err, in_m, in_n, in_data, clr, rd_en, rd_idx,
    input  rd_valid, rd_err, rd_m, rd_n, rd_data,
    input  wr_ack, wr_idx, wr_replaced, used_cnt
  );

  modport slave (
    input  in_done, in_err, in_m, in_n, in_data, clr, rd_en, rd_idx,
    output rd_valid, rd_err, rd_m, rd_n, rd_data,
    output wr_ack, wr_idx, wr_replaced, used_cnt
  );

endinterface

// File: rtl/matrix_store_victim.sv
// Combinational victim selection and age update for the matrix bank.
// Priority: evict the oldest entry of the same shape once that shape has
// reached its quota; otherwise take the lowest free slot; otherwise evict
// the globally oldest entry. Age 0 is the newest entry.
module matrix_store_victim
  import matrix_pkg::*;
#(
  parameter int MAX_MATS = 8,
  parameter int PER_DIM  = 2
) (
  input  logic [MAX_MATS-1:0]       valid,
  input  logic [MAX_MATS-1:0][3:0]  m,
  input  logic [MAX_MATS-1:0][3:0]  n,
  input  logic [MAX_MATS-1:0][2:0]  age,
  input  dim_t                      in_m,
  input  dim_t                      in_n,
  output idx_t                      victim,
  output logic                      replace,
  output logic [MAX_MATS-1:0][2:0]  age_next
);

  logic [3:0] match_cnt;
  logic       match_found;
  idx_t       match_idx;
  age_t       match_age;
  logic       free_found;
  idx_t       free_idx;
  logic       old_found;
  idx_t       old_idx;
  age_t       old_age;
  age_t       victim_age;
  logic       quota_hit;

  // Scan all entries for shape matches, the first free slot and the oldest entry.
  always_comb begin
    match_cnt   = '0;
    match_found = 1'b0;
    match_idx   = '0;
    match_age   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    old_found   = 1'b0;
    old_idx     = '0;
    old_age     = '0;
    for (int i = 0; i < MAX_MATS; i++) begin
      if (valid[i] && (m[i] == in_m) && (n[i] == in_n)) begin
        match_cnt = match_cnt + 4'd1;
        if (!match_found || (age[i] > match_age)) begin
          match_found = 1'b1;
          match_idx   = idx_t'(i);
          match_age   = age[i];
        end
      end
      if (!valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = idx_t'(i);
      end
      if (valid[i] && (!old_found || (age[i] > old_age))) begin
        old_found = 1'b1;
        old_idx   = idx_t'(i);
        old_age   = age[i];
      end
    end
  end

  // Apply the three selection rules in priority order.
  always_comb begin
    quota_hit  = (match_cnt >= 4'(PER_DIM));
    victim     = '0;
    replace    = 1'b0;
    victim_age = '0;
    if (quota_hit) begin
      victim     = match_idx;
      replace    = 1'b1;
      victim_age = match_age;
    end else if (free_found) begin
      victim     = free_idx;
      replace    = 1'b0;
    end else begin
      victim     = old_idx;
      replace    = 1'b1;
      victim_age = old_age;
    end
  end

  // Victim becomes newest; entries younger than the evicted one (or all
  // entries when filling a free slot) get one step older.
  always_comb begin
    for (int i = 0; i < MAX_MATS; i++) begin
      age_next[i] = age[i];
      if (victim == idx_t'(i)) begin
        age_next[i] = '0;
      end else if (valid[i] && (!replace || (age[i] < victim_age))) begin
        if (age[i] < age_t'(MAX_MATS - 1)) begin
          age_next[i] = age[i] + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/matrix_store.sv
// Matrix storage bank: captures validated matrices from the input parser,
// keeps at most PER_DIM entries per (m,n) shape in MAX_MATS slots with
// oldest-first replacement, and serves a registered indexed read port.
module matrix_store
  import matrix_pkg::*;
#(
  parameter int MAX_MATS = 8,
  parameter int PER_DIM  = 2
) (
  input logic           clk,
  input logic           rst_n,
  matrix_store_if.slave bus
);

  logic [MAX_MATS-1:0]      valid_q;
  logic [MAX_MATS-1:0][3:0] m_q;
  logic [MAX_MATS-1:0][3:0] n_q;
  logic [MAX_MATS-1:0][2:0] age_q;
  mat_t                     data_q [MAX_MATS];

  idx_t                     victim;
  logic                     replace;
  logic [MAX_MATS-1:0][2:0] age_next;
  logic                     capture;

  logic                     rd_hit;
  dim_t                     rd_sel_m;
  dim_t                     rd_sel_n;
  mat_t                     rd_sel_data;

  matrix_store_victim #(
    .MAX_MATS (MAX_MATS),
    .PER_DIM  (PER_DIM)
  ) u_victim (
    .valid    (valid_q),
    .m        (m_q),
    .n        (n_q),
    .age      (age_q),
    .in_m     (bus.in_m),
    .in_n     (bus.in_n),
    .victim   (victim),
    .replace  (replace),
    .age_next (age_next)
  );

  // Accept a strobe only for clean, in-range matrices; clear takes precedence.
  always_comb begin
    capture = bus.in_done && (bus.in_err == ERR_NONE) &&
              dim_ok(bus.in_m) && dim_ok(bus.in_n) && !bus.clr;
  end

  // Read mux over the current (pre-write, pre-clear) contents.
  always_comb begin
    rd_hit      = 1'b0;
    rd_sel_m    = '0;
    rd_sel_n    = '0;
    rd_sel_data = '0;
    for (int i = 0; i < MAX_MATS; i++) begin
      if ((bus.rd_idx == idx_t'(i)) && valid_q[i]) begin
        rd_hit      = 1'b1;
        rd_sel_m    = m_q[i];
        rd_sel_n    = n_q[i];
        rd_sel_data = data_q[i];
      end
    end
  end

  // Entry storage: clear, or write the victim slot and re-age the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      m_q     <= '0;
      n_q     <= '0;
      age_q   <= '0;
      for (int i = 0; i < MAX_MATS; i++) begin
        data_q[i] <= '0;
      end
    end else if (bus.clr) begin
      valid_q <= '0;
      age_q   <= '0;
    end else if (capture) begin
      age_q <= age_next;
      for (int i = 0; i < MAX_MATS; i++) begin
        if (victim == idx_t'(i)) begin
          valid_q[i] <= 1'b1;
          m_q[i]     <= bus.in_m;
          n_q[i]     <= bus.in_n;
          data_q[i]  <= mask_data(bus.in_data, bus.in_m, bus.in_n);
        end
      end
    end
  end

  // Write acknowledge and occupancy count; only a free-slot fill grows the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wr_ack      <= 1'b0;
      bus.wr_idx      <= '0;
      bus.wr_replaced <= 1'b0;
      bus.used_cnt    <= '0;
    end else begin
      bus.wr_ack      <= capture;
      bus.wr_idx      <= capture ? victim : '0;
      bus.wr_replaced <= capture && replace;
      if (bus.clr) begin
        bus.used_cnt <= '0;
      end else if (capture && !replace && (bus.used_cnt < 4'(MAX_MATS))) begin
        bus.used_cnt <= bus.used_cnt + 4'd1;
      end
    end
  end

  // Registered read port; data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_valid <= 1'b0;
      bus.rd_err   <= 1'b0;
      bus.rd_m     <= '0;
      bus.rd_n     <= '0;
      bus.rd_data  <= '0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        bus.rd_err  <= !rd_hit;
        bus.rd_m    <= rd_sel_m;
        bus.rd_n    <= rd_sel_n;
        bus.rd_data <= rd_sel_data;
      end
    end
  end

endmodule

// File: tb/tb_matrix_store.sv
// Testbench for matrix_store: directed scenarios plus a randomized run, all
// checked against a recency-timestamp model of the storage bank.
module tb_matrix_store;
  import matrix_pkg::*;

  localparam int MAX_MATS = 8;
  localparam int PER_DIM  = 2;

  typedef struct packed {
    logic       wr_ack;
    logic [2:0] wr_idx;
    logic       wr_replaced;
    logic [3:0] used_cnt;
    logic       rd_valid;
    logic       rd_err;
    logic [3:0] rd_m;
    logic [3:0] rd_n;
    logic [99:0] rd_data;
  } obs_t;

  logic clk;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  matrix_store_if bus ();

  matrix_store #(.MAX_MATS(MAX_MATS), .PER_DIM(PER_DIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each slot remembers when it was written; "oldest" is the smallest stamp.
  logic        mv [MAX_MATS];
  logic [3:0]  mm [MAX_MATS];
  logic [3:0]  mn [MAX_MATS];
  logic [99:0] md [MAX_MATS];
  int          ms [MAX_MATS];
  int          stamp;
  int          mused;
  obs_t        mexp;

  function automatic logic [99:0] model_mask(input logic [99:0] d, input int m, input int n);
    logic [99:0] r;
    r = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        if (i < m && j < n) r[(i*5+j)*4 +: 4] = d[(i*5+j)*4 +: 4];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < MAX_MATS; i++) begin
      mv[i] = 1'b0; mm[i] = '0; mn[i] = '0; md[i] = '0; ms[i] = 0;
    end
    stamp = 0;
    mused = 0;
    mexp  = '0;
  endtask

  task automatic model_step(input logic done, input logic [2:0] err, input logic [3:0] m,
                            input logic [3:0] n, input logic [99:0] d, input logic c,
                            input logic re, input logic [2:0] ri);
    int cnt, best, v;
    mexp.wr_ack = 1'b0; mexp.wr_idx = '0; mexp.wr_replaced = 1'b0;
    mexp.rd_valid = re;
    if (re) begin
      if (int'(ri) < MAX_MATS && mv[ri]) begin
        mexp.rd_err = 1'b0; mexp.rd_m = mm[ri]; mexp.rd_n = mn[ri]; mexp.rd_data = md[ri];
      end else begin
        mexp.rd_err = 1'b1; mexp.rd_m = '0; mexp.rd_n = '0; mexp.rd_data = '0;
      end
    end
    if (c) begin
      for (int i = 0; i < MAX_MATS; i++) mv[i] = 1'b0;
      mused = 0;
    end else if (done && err == 3'b000 && m >= 1 && m <= 5 && n >= 1 && n <= 5) begin
      cnt = 0; best = -1;
      for (int i = 0; i < MAX_MATS; i++)
        if (mv[i] && mm[i] == m && mn[i] == n) begin
          cnt++;
          if (best < 0 || ms[i] < ms[best]) best = i;
        end
      if (cnt >= PER_DIM) begin
        v = best; mexp.wr_replaced = 1'b1;
      end else begin
        v = -1;
        for (int i = 0; i < MAX_MATS; i++) if (!mv[i] && v < 0) v = i;
        if (v >= 0) begin
          mused++;
        end else begin
          v = 0;
          for (int i = 1; i < MAX_MATS; i++) if (ms[i] < ms[v]) v = i;
          mexp.wr_replaced = 1'b1;
        end
      end
      mv[v] = 1'b1; mm[v] = m; mn[v] = n; md[v] = model_mask(d, m, n);
      ms[v] = stamp; stamp++;
      mexp.wr_ack = 1'b1; mexp.wr_idx = 3'(v);
    end
    mexp.used_cnt = 4'(mused);
  endtask

  // ---------------- driver ----------------
  function automatic obs_t sample();
    obs_t o;
    o.wr_ack = bus.wr_ack; o.wr_idx = bus.wr_idx; o.wr_replaced = bus.wr_replaced;
    o.used_cnt = bus.used_cnt; o.rd_valid = bus.rd_valid; o.rd_err = bus.rd_err;
    o.rd_m = bus.rd_m; o.rd_n = bus.rd_n; o.rd_data = bus.rd_data;
    return o;
  endfunction

  // Drive one cycle of inputs (called #1 after a rising edge), then sample #1
  // after the next edge. wr_idx/wr_replaced are ignored when no ack is due.
  task automatic step(input logic done, input logic [2:0] err, input logic [3:0] m,
                      input logic [3:0] n, input logic [99:0] d, input logic c,
                      input logic re, input logic [2:0] ri, output obs_t got, output obs_t exp);
    bus.in_done = done; bus.in_err = err; bus.in_m = m; bus.in_n = n; bus.in_data = d;
    bus.clr = c; bus.rd_en = re; bus.rd_idx = ri;
    model_step(done, err, m, n, d, c, re, ri);
    exp = mexp;
    @(posedge clk); #1;
    bus.in_done = 1'b0; bus.clr = 1'b0; bus.rd_en = 1'b0;
    got = sample();
    if (!exp.wr_ack) begin
      got.wr_idx = '0; got.wr_replaced = 1'b0; exp.wr_idx = '0; exp.wr_replaced = 1'b0;
    end
  endtask

  function automatic logic [99:0] rand_data();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[99:0];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t got;
    bus.in_done = 0; bus.in_err = 0; bus.in_m = 0; bus.in_n = 0; bus.in_data = '0;
    bus.clr = 0; bus.rd_en = 0; bus.rd_idx = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    got = sample();
    checks++;
    if (got !== obs_t'('0)) $display("FAIL reset_outputs: got %h expected 0", got);
    else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_store_basic();
    obs_t got, exp;
    logic [99:0] d, want;
    d = rand_data(); want = '0;
    for (int k = 1; k <= 6; k++) begin
      d[(((k-1)/3)*5 + (k-1)%3)*4 +: 4] = 4'(k);
      want[(((k-1)/3)*5 + (k-1)%3)*4 +: 4] = 4'(k);
    end
    step(1, 3'b000, 2, 3, d, 0, 0, 0, got, exp);
    checks++;
    if (got !== exp || got.wr_ack !== 1'b1 || got.wr_idx !== 3'd0 || got.wr_replaced !== 1'b0 ||
        got.used_cnt !== 4'd1)
      $display("FAIL store_first: got %h expected %h", got, exp);
    else passes++;
    step(0, 0, 0, 0, '0, 0, 1, 0, got, exp);
    checks++;
    if (got !== exp || got.rd_m !== 4'd2 || got.rd_n !== 4'd3 || got.rd_data !== want)
      $display("FAIL read_first: got %h expected %h", got, exp);
    else passes++;
    step(0, 0, 0, 0, '0, 0, 0, 0, got, exp);
    checks++;
    if (got !== exp || got.rd_valid !== 1'b0 || got.rd_data !== want)
      $display("FAIL read_hold: got %h expected %h", got, exp);
    else passes++;
  endtask

  task automatic test_bad_input();
    obs_t got, exp;
    step(1, 3'b011, 2, 2, rand_data(), 0, 0, 0, got, exp);
    checks++;
    if (got !== exp || got.wr_ack !== 1'b0 || got.used_cnt !== 4'd1)
      $display("FAIL bad_err: got %h expected %h", got, exp);
    else passes++;
    step(1, 3'b000, 6, 2, rand_data(), 0, 0, 0, got, exp);
    checks++;
    if (got !== exp || got.wr_ack !== 1'b0 || got.used_cnt !== 4'd1)
      $display("FAIL bad_m6: got %h expected %h", got, exp);
    else passes++;
    step(1, 3'b000, 3, 0, rand_data(), 0, 0, 0, got, exp);
    checks++;
    if (got !== exp) $display("FAIL bad_n0: got %h expected %h", got, exp);
    else passes++;
  endtask

  task automatic test_per_dim_replace();
    obs_t got, exp;
    logic [99:0] c_data;
    step(0, 0, 0, 0, '0, 1, 0, 0, got, exp);
    step(1, 0, 3, 3, rand_data(), 0, 0, 0, got, exp);
    step(1, 0, 3, 3, rand_data(), 0, 0, 0, got, exp);
    c_data = rand_data();
    step(1, 0, 3, 3, c_data, 0, 0, 0, got, exp);
    checks++;
    if (got !== exp || got.wr_idx !== 3'd0 || got.wr_replaced !== 1'b1 || got.used_cnt !== 4'd2)
      $display("FAIL per_dim_victim: got %h expected %h", got, exp);
    else passes++;
    step(0, 0, 0, 0, '0, 0, 1, 0, got, exp);
    checks++;
    if (got !== exp || got.rd_data !== model_mask(c_data, 3, 3))
      $display("FAIL per_dim_read: got %h expected %h", got, exp);
    else passes++;
  endtask

  task automatic test_fill_evict();
    obs_t got, exp;
    step(0, 0, 0, 0, '0, 1, 0, 0, got, exp);
    for (int k = 0; k < MAX_MATS; k++) begin
      step(1, 0, 4'(1 + k/4), 4'(2 + k%4), rand_data(), 0, 0, 0, got, exp);
      checks++;
      if (got !== exp) $display("FAIL fill_%0d: got %h expected %h", k, got, exp);
      else passes++;
    end
    step(1, 0, 1, 1, rand_data(), 0, 0, 0, got, exp);
    checks++;
    if (got !== exp || got.wr_idx !== 3'd0 || got.wr_replaced !== 1'b1 || got.used_cnt !== 4'd8)
      $display("FAIL full_evict: got %h expected %h", got, exp);
    else passes++;
  endtask

  task automatic test_read_collision();
    obs_t got, exp;
    logic [99:0] x;
    step(0, 0, 0, 0, '0, 1, 0, 0, got, exp);
    step(0, 0, 0, 0, '0, 0, 1, 5, got, exp);
    checks++;
    if (got !== exp || got.rd_valid !== 1'b1 || got.rd_err !== 1'b1 || got.rd_data !== '0)
      $display("FAIL read_empty: got %h expected %h", got, exp);
    else passes++;
    x = rand_data();
    step(1, 0, 2, 2, x, 0, 0, 0, got, exp);
    step(1, 0, 2, 2, rand_data(), 0, 0, 0, got, exp);
    step(1, 0, 2, 2, rand_data(), 0, 1, 0, got, exp);
    checks++;
    if (got !== exp || got.wr_idx !== 3'd0 || got.rd_data !== model_mask(x, 2, 2))
      $display("FAIL read_during_write: got %h expected %h", got, exp);
    else passes++;
  endtask

  task automatic test_clr();
    obs_t got, exp;
    step(1, 0, 1, 4, rand_data(), 1, 1, 0, got, exp);
    checks++;
    if (got !== exp || got.wr_ack !== 1'b0 || got.used_cnt !== 4'd0 || got.rd_err !== 1'b0)
      $display("FAIL clr_vs_write: got %h expected %h", got, exp);
    else passes++;
    step(0, 0, 0, 0, '0, 0, 1, 1, got, exp);
    checks++;
    if (got !== exp || got.rd_err !== 1'b1) $display("FAIL after_clr_read: got %h expected %h", got, exp);
    else passes++;
  endtask

  task automatic test_back_to_back_reads();
    obs_t got, exp;
    step(1, 0, 5, 5, rand_data(), 0, 0, 0, got, exp);
    step(1, 0, 4, 1, rand_data(), 0, 0, 0, got, exp);
    for (int k = 0; k < 4; k++) begin
      bus.rd_en = 1'b1;
      step(0, 0, 0, 0, '0, 0, 1, 3'(k), got, exp);
      checks++;
      if (got !== exp) $display("FAIL b2b_read_%0d: got %h expected %h", k, got, exp);
      else passes++;
    end
  endtask

  task automatic test_random();
    obs_t got, exp;
    logic done, c, re;
    logic [2:0] err;
    logic [3:0] m, n;
    int fails_before;
    for (int k = 0; k < 400; k++) begin
      done = ($urandom_range(0, 99) < 60);
      err  = ($urandom_range(0, 99) < 10) ? 3'($urandom_range(1, 7)) : 3'b000;
      m    = 4'($urandom_range(1, 3));
      n    = 4'($urandom_range(1, 2));
      if ($urandom_range(0, 99) < 5) m = 4'($urandom_range(6, 15));
      if ($urandom_range(0, 99) < 3) n = 4'd0;
      c    = ($urandom_range(0, 99) < 3);
      re   = ($urandom_range(0, 99) < 50);
      fails_before = checks - passes;
      step(done, err, m, n, rand_data(), c, re, 3'($urandom_range(0, 7)), got, exp);
      checks++;
      if (got !== exp) $display("FAIL random_%0d: got %h expected %h", k, got, exp);
      else passes++;
      if (checks - passes > fails_before + 20) break;
    end
  endtask

  task automatic test_reset_mid_read();
    obs_t got, exp;
    step(1, 0, 2, 5, rand_data(), 0, 0, 0, got, exp);
    step(0, 0, 0, 0, '0, 0, 1, 0, got, exp);
    checks++;
    if (got !== exp || got.rd_valid !== 1'b1) $display("FAIL pre_reset_read: got %h expected %h", got, exp);
    else passes++;
    bus.rd_en = 1'b1; bus.rd_idx = 3'd0;
    rst_n = 1'b0;
    #2;
    got = sample();
    checks++;
    if (got !== obs_t'('0)) $display("FAIL async_reset: got %h expected 0", got);
    else passes++;
    @(posedge clk); #1;
    got = sample();
    checks++;
    if (got !== obs_t'('0)) $display("FAIL held_reset: got %h expected 0", got);
    else passes++;
    bus.rd_en = 1'b0;
    rst_n = 1'b1;
    model_reset();
    step(0, 0, 0, 0, '0, 0, 1, 0, got, exp);
    checks++;
    if (got !== exp || got.rd_err !== 1'b1) $display("FAIL post_reset_read: got %h expected %h", got, exp);
    else passes++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_store_basic();
    test_bad_input();
    test_per_dim_replace();
    test_fill_evict();
    test_read_collision();
    test_clr();
    test_back_to_back_reads();
    test_random();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
